// File: rtl/mon_mult_param.sv
// Radix-2 bit-serial Montgomery multiplier: p = a*b*2^-WIDTH mod m.
// One iteration per clock, operands latched on start, abortable, flags an even modulus.
module mon_mult_param #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             pclk,
    input  logic             nreset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    generate
        if (WIDTH < 4) begin : g_width_check
            $error("mon_mult_param: WIDTH must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_r, b_r, m_r;
    logic [WIDTH+1:0] t;
    logic [CNT_W-1:0] cnt;
    logic             even_r;

    logic             accept;
    logic             last_iter;
    logic             a_bit;
    logic             q;
    logic [WIDTH+2:0] sum;
    logic [WIDTH+1:0] t_nx;
    logic [WIDTH+1:0] t_sub;
    logic [WIDTH-1:0] p_fin;

    // a_r is shifted right each iteration, so bit i of the latched multiplicand sits in a_r[0]
    assign a_bit     = a_r[0];
    assign q         = t[0] ^ (a_bit & b_r[0]);
    assign sum       = {1'b0, t}
                     + (a_bit ? {3'b000, b_r} : '0)
                     + (q     ? {3'b000, m_r} : '0);
    assign t_nx      = sum[WIDTH+2:1];
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign t_sub     = t - {2'b00, m_r};
    assign p_fin     = (t >= {2'b00, m_r}) ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];

    assign ready = (state == IDLE);
    assign busy  = (state == CALC) || (state == FINAL);

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                // start beats a simultaneous abort here; abort only matters while busy
                if (start) begin
                    accept   = 1'b1;
                    state_nx = m[0] ? CALC : FINAL;
                end
            end
            CALC: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last_iter) begin
                    state_nx = FINAL;
                end
            end
            FINAL: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            t      <= '0;
            cnt    <= '0;
            even_r <= 1'b0;
            p      <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept) begin
                a_r    <= a;
                b_r    <= b;
                m_r    <= m;
                t      <= '0;
                cnt    <= '0;
                even_r <= ~m[0];
            end else if (state == CALC && !abort) begin
                t   <= t_nx;
                a_r <= a_r >> 1;
                cnt <= cnt + CNT_W'(1);
            end else if (state == FINAL && !abort) begin
                done <= 1'b1;
                err  <= even_r;
                p    <= even_r ? '0 : p_fin;
            end
        end
    end

endmodule

// File: tb/tb_mon_mult_param.sv
// Directed bench for mon_mult_param: table of 8-bit vectors plus hand-written
// back-to-back, abort, reset and 64-bit sequences.
module tb_mon_mult_param;

    logic        pclk;
    logic        nreset;

    logic        start8, abort8;
    logic [7:0]  a8, b8, m8, p8;
    logic        ready8, busy8, done8, err8;

    logic        start64, abort64;
    logic [63:0] a64, b64, m64, p64;
    logic        ready64, busy64, done64, err64;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] exp_p;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    mon_mult_param #(.WIDTH(8)) dut8 (
        .pclk(pclk), .nreset(nreset), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .m(m8), .p(p8),
        .ready(ready8), .busy(busy8), .done(done8), .err(err8)
    );

    mon_mult_param #(.WIDTH(64)) dut64 (
        .pclk(pclk), .nreset(nreset), .start(start64), .abort(abort64),
        .a(a64), .b(b64), .m(m64), .p(p64),
        .ready(ready64), .busy(busy64), .done(done64), .err(err64)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver: called at a negedge, start is seen by the next rising edge
    task automatic launch8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tm);
        a8     = ta;
        b8     = tb;
        m8     = tm;
        start8 = 1'b1;
        @(negedge pclk);
        start8 = 1'b0;
    endtask

    // lat = rising edges after the accepting edge until done is visible
    task automatic wait_done8(output logic [7:0] rp, output logic rerr,
                              output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        rp   = '0;
        rerr = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (done8) begin
                lat  = j - 1;
                rp   = p8;
                rerr = err8;
                break;
            end
            if (busy8) bcnt++;
            @(negedge pclk);
        end
    endtask

    initial begin
        logic [7:0] rp;
        logic       rerr;
        int         lat;
        int         bcnt;
        int         seen;
        logic [7:0] prev_p;

        checks   = 0;
        failures = 0;
        nreset   = 1'b0;
        start8   = 1'b0;
        abort8   = 1'b0;
        a8       = '0;
        b8       = '0;
        m8       = '0;
        start64  = 1'b0;
        abort64  = 1'b0;
        a64      = '0;
        b64      = '0;
        m64      = '0;

        vecs[0] = '{8'd1,   8'd1,   8'd13,  8'd3,   1'b0};
        vecs[1] = '{8'd5,   8'd7,   8'd13,  8'd1,   1'b0};
        vecs[2] = '{8'd7,   8'd11,  8'd13,  8'd10,  1'b0};
        vecs[3] = '{8'd12,  8'd12,  8'd13,  8'd3,   1'b0};
        vecs[4] = '{8'd254, 8'd254, 8'd255, 8'd1,   1'b0};
        vecs[5] = '{8'd100, 8'd200, 8'd251, 8'd235, 1'b0};
        vecs[6] = '{8'd250, 8'd250, 8'd251, 8'd201, 1'b0};
        vecs[7] = '{8'd3,   8'd4,   8'd12,  8'd0,   1'b1};
        vecs[8] = '{8'd0,   8'd9,   8'd13,  8'd0,   1'b0};

        repeat (2) @(negedge pclk);
        check("reset_p",     {56'd0, p8}, 64'd0);
        check("reset_ready", {63'd0, ready8}, 64'd1);
        check("reset_busy",  {63'd0, busy8}, 64'd0);
        check("reset_done",  {63'd0, done8}, 64'd0);
        check("reset_err",   {63'd0, err8}, 64'd0);
        nreset = 1'b1;
        @(negedge pclk);

        // table-driven vectors
        for (int i = 0; i < 9; i++) begin
            launch8(vecs[i].a, vecs[i].b, vecs[i].m);
            wait_done8(rp, rerr, lat, bcnt);
            check($sformatf("vec%0d_p", i),   {56'd0, rp}, {56'd0, vecs[i].exp_p});
            check($sformatf("vec%0d_err", i), {63'd0, rerr}, {63'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), 64'(lat), vecs[i].exp_err ? 64'd1 : 64'd9);
            check($sformatf("vec%0d_busy", i), 64'(bcnt), vecs[i].exp_err ? 64'd1 : 64'd9);
            @(negedge pclk);
            check($sformatf("vec%0d_done_pulse", i), {63'd0, done8}, 64'd0);
            check($sformatf("vec%0d_err_pulse", i),  {63'd0, err8}, 64'd0);
        end

        // back-to-back: second start issued in the done cycle
        launch8(8'd5, 8'd7, 8'd13);
        wait_done8(rp, rerr, lat, bcnt);
        check("b2b_first_p",   {56'd0, rp}, 64'd1);
        check("b2b_ready_in_done", {63'd0, ready8}, 64'd1);
        launch8(8'd0, 8'd9, 8'd13);
        check("b2b_no_gap_busy", {63'd0, busy8}, 64'd1);
        wait_done8(rp, rerr, lat, bcnt);
        check("b2b_second_p",   {56'd0, rp}, 64'd0);
        check("b2b_second_lat", 64'(lat), 64'd9);

        // ignored start while busy, then abort mid-CALC
        launch8(8'd7, 8'd11, 8'd13);
        wait_done8(rp, rerr, lat, bcnt);
        check("pre_abort_p", {56'd0, rp}, 64'd10);
        prev_p = 8'd10;
        @(negedge pclk);
        launch8(8'd5, 8'd7, 8'd13);
        repeat (2) @(negedge pclk);
        start8 = 1'b1;
        a8     = 8'd1;
        b8     = 8'd1;
        m8     = 8'd12;
        @(negedge pclk);
        start8 = 1'b0;
        check("busy_start_ignored", {63'd0, busy8}, 64'd1);
        @(negedge pclk);
        abort8 = 1'b1;
        @(negedge pclk);
        abort8 = 1'b0;
        check("abort_ready", {63'd0, ready8}, 64'd1);
        check("abort_busy",  {63'd0, busy8}, 64'd0);
        check("abort_p_held", {56'd0, p8}, {56'd0, prev_p});
        seen = 0;
        for (int j = 0; j < 12; j++) begin
            if (done8 || err8) seen++;
            @(negedge pclk);
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_p_still", {56'd0, p8}, {56'd0, prev_p});
        launch8(8'd5, 8'd7, 8'd13);
        wait_done8(rp, rerr, lat, bcnt);
        check("post_abort_p",   {56'd0, rp}, 64'd1);
        check("post_abort_lat", 64'(lat), 64'd9);

        // abort together with start in IDLE: start wins
        @(negedge pclk);
        abort8 = 1'b1;
        launch8(8'd1, 8'd1, 8'd13);
        abort8 = 1'b0;
        wait_done8(rp, rerr, lat, bcnt);
        check("idle_abort_start_p",   {56'd0, rp}, 64'd3);
        check("idle_abort_start_lat", 64'(lat), 64'd9);

        // asynchronous reset mid-CALC
        @(negedge pclk);
        launch8(8'd5, 8'd7, 8'd13);
        repeat (3) @(negedge pclk);
        #2 nreset = 1'b0;
        #1;
        check("async_rst_p",     {56'd0, p8}, 64'd0);
        check("async_rst_ready", {63'd0, ready8}, 64'd1);
        check("async_rst_busy",  {63'd0, busy8}, 64'd0);
        check("async_rst_done",  {63'd0, done8}, 64'd0);
        @(negedge pclk);
        nreset = 1'b1;
        @(negedge pclk);
        launch8(8'd1, 8'd1, 8'd13);
        wait_done8(rp, rerr, lat, bcnt);
        check("post_rst_p",   {56'd0, rp}, 64'd3);
        check("post_rst_lat", 64'(lat), 64'd9);

        // 64-bit instance, m = 2^64-1 so R == 1 mod m
        @(negedge pclk);
        a64     = 64'd2;
        b64     = 64'd3;
        m64     = '1;
        start64 = 1'b1;
        @(negedge pclk);
        start64 = 1'b0;
        lat     = -1;
        for (int j = 1; j <= 100; j++) begin
            if (done64) begin
                lat = j - 1;
                break;
            end
            @(negedge pclk);
        end
        check("w64_lat", 64'(lat), 64'd65);
        check("w64_p",   p64, 64'd6);
        check("w64_err", {63'd0, err64}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
